// File: rtl/prga_fifo_pkg.sv
// Shared definitions for the prga_fifo family of blocks.
package prga_fifo_pkg;

    // Counter width for an upsizer packing `ratio` narrow entries per wide word.
    function automatic int unsigned PRGA_FIFO_UPSIZER_CNT_WIDTH(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage : prga_fifo_pkg

// File: rtl/prga_fifo_upsizer.sv
// Width-up converter behind a lookahead FIFO: packs RATIO narrow entries
// little-endian into one wide word and re-presents it as a lookahead FIFO.
// Optional partial-word flush is enabled with `define PRGA_FIFO_UPSIZER_FLUSH_EN.
module prga_fifo_upsizer
    import prga_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          empty_i,
    output logic                          rd_i,
    input  logic [DATA_WIDTH-1:0]         dout_i,
    output logic                          empty,
    input  logic                          rd,
    output logic [DATA_WIDTH*RATIO-1:0]   dout,
    output logic                          busy
`ifdef PRGA_FIFO_UPSIZER_FLUSH_EN
    ,
    input  logic                          flush,
    output logic [RATIO-1:0]              dout_mask
`endif
);

    localparam int unsigned CNT_W = PRGA_FIFO_UPSIZER_CNT_WIDTH(RATIO);
    localparam int unsigned OUT_W = DATA_WIDTH * RATIO;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [RATIO-2:0][DATA_WIDTH-1:0]   pack_q, pack_d;
    logic [OUT_W-1:0]                   out_data_q, out_data_d;
    logic                               out_valid_q, out_valid_d;
    logic                               pop_c;
    logic                               emit_c;
    logic [OUT_W-1:0]                   word_c;
`ifdef PRGA_FIFO_UPSIZER_FLUSH_EN
    logic [RATIO-1:0]                   mask_q, mask_d;
    logic [RATIO-1:0]                   lanes_c;
`endif

    // Upstream pop, candidate output word and next-state computation.
    always_comb begin
        pop_c       = rst && !empty_i && ((cnt_q != CNT_LAST) || !out_valid_q || rd);
        emit_c      = pop_c && (cnt_q == CNT_LAST);
        word_c      = '0;
        cnt_d       = cnt_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        // Filled pack lanes plus the entry popped this edge at lane cnt.
        for (int i = 0; i < int'(RATIO) - 1; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                word_c[i*DATA_WIDTH +: DATA_WIDTH] = pack_q[i];
            end
        end
        if (pop_c) begin
            word_c[cnt_q*DATA_WIDTH +: DATA_WIDTH] = dout_i;
        end

`ifdef PRGA_FIFO_UPSIZER_FLUSH_EN
        mask_d  = mask_q;
        lanes_c = '0;
        for (int i = 0; i < int'(RATIO) - 1; i++) begin
            lanes_c[i] = (CNT_W'(i) < cnt_q);
        end
        if (pop_c) begin
            lanes_c[cnt_q] = 1'b1;
        end
        // A flush only fires when there is something to emit and room for it.
        if (flush && ((cnt_q != '0) || pop_c) && (!out_valid_q || rd)) begin
            emit_c = 1'b1;
        end
`endif

        if (emit_c) begin
            out_data_d  = word_c;
            out_valid_d = 1'b1;
            cnt_d       = '0;
`ifdef PRGA_FIFO_UPSIZER_FLUSH_EN
            mask_d      = lanes_c;
`endif
        end else begin
            if (pop_c) begin
                for (int i = 0; i < int'(RATIO) - 1; i++) begin
                    if (CNT_W'(i) == cnt_q) begin
                        pack_d[i] = dout_i;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (rd && out_valid_q) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef PRGA_FIFO_UPSIZER_FLUSH_EN
            mask_q      <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef PRGA_FIFO_UPSIZER_FLUSH_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign rd_i  = pop_c;
    assign empty = !out_valid_q;
    assign dout  = out_data_q;
    assign busy  = (cnt_q != '0);
`ifdef PRGA_FIFO_UPSIZER_FLUSH_EN
    assign dout_mask = mask_q;
`endif

endmodule : prga_fifo_upsizer
